usr_ex_responder: RTL and testbench

- User-CPU-side end of the incremental-development execute protocol.
- Accepts one injected instruction at a time from the incremental controller and issues it into the user pipeline's fetch slot at the architectural PC.
- Waits for that instruction to retire, then returns a one-cycle finish pulse.
- Owns the user CPU's architectural PC and applies controller-driven PC increments, PC overwrites and register-file writebacks for instructions the user CPU does not implement.

---
 rtl/usr_ex_responder_pkg.sv | 27 ++
 rtl/usr_rf_wb_buf.sv | 71 +++++++
 rtl/usr_ex_responder.sv | 164 ++++++++++++++++
 tb/tb_usr_ex_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_ex_responder_pkg.sv
// Shared types and constants for the user-side execute responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package usr_ex_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ex_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    // Bit positions inside the sticky error vector
    localparam int ERR_PROTO   = 0;
    localparam int ERR_OVF     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_W       = 3;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wr_t;

endpackage

// File: rtl/usr_rf_wb_buf.sv
// Controller register writebacks onto the RF override port, 1-entry buffer.
// Latency: 0 cycles when the RF port is free and the buffer is empty, else drains on first free cycle.
// Backpressure: none upstream; a write arriving while full and the port busy is dropped and flagged.
module usr_rf_wb_buf
    import usr_ex_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_wreg_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        cpu_rf_we_i,
    output logic        rf_ov_we_o,
    output logic [4:0]  rf_ov_waddr_o,
    output logic [31:0] rf_ov_wdata_o,
    output logic        ovf_o
);

    logic   buf_vld_q, buf_vld_d;
    rf_wr_t buf_q, buf_d;
    logic   wr_vld;
    rf_wr_t wr;

    // r0 is hardwired zero, so writes to it are simply discarded
    assign wr_vld = wb_we_i && (wb_wreg_i != 5'd0);
    assign wr     = {wb_wreg_i, wb_wdata_i};

    // Buffered entry always drains before a new write may bypass
    always_comb begin
        buf_vld_d     = buf_vld_q;
        buf_d         = buf_q;
        rf_ov_we_o    = 1'b0;
        rf_ov_waddr_o = 5'd0;
        rf_ov_wdata_o = 32'd0;
        ovf_o         = 1'b0;
        if (!cpu_rf_we_i) begin
            if (buf_vld_q) begin
                rf_ov_we_o    = 1'b1;
                rf_ov_waddr_o = buf_q.waddr;
                rf_ov_wdata_o = buf_q.wdata;
                buf_vld_d     = wr_vld;
                if (wr_vld) begin
                    buf_d = wr;
                end
            end else if (wr_vld) begin
                rf_ov_we_o    = 1'b1;
                rf_ov_waddr_o = wr.waddr;
                rf_ov_wdata_o = wr.wdata;
            end
        end else if (wr_vld) begin
            if (buf_vld_q) begin
                ovf_o = 1'b1;
            end else begin
                buf_vld_d = 1'b1;
                buf_d     = wr;
            end
        end
    end

    // Buffer storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: rtl/usr_ex_responder.sv
// Issues injected instructions into the user fetch slot, waits for retire, pulses ex_finish; owns arch PC.
// Latency: ex_flag -> inj_valid 1 cycle; cpu_retire -> ex_finish 1 cycle.
// Backpressure: offer held until inj_ready; one instruction in flight, extra ex_flag dropped and flagged.
module usr_ex_responder
    import usr_ex_responder_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [7:0]  TIMEOUT  = 8'd255
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_flag,
    input  logic [31:0] ex_inst,
    output logic        ex_finish,
    input  logic        pc_inc,
    input  logic        pc_we,
    input  logic [31:0] pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_wreg,
    input  logic [31:0] wb_wdata,
    output logic        inj_valid,
    output logic [31:0] inj_inst,
    output logic [31:0] inj_pc,
    input  logic        inj_ready,
    input  logic        cpu_retire,
    input  logic        cpu_npc_vld,
    input  logic [31:0] cpu_npc,
    input  logic        cpu_rf_we,
    output logic        rf_ov_we,
    output logic [4:0]  rf_ov_waddr,
    output logic [31:0] rf_ov_wdata,
    output logic [31:0] arch_pc,
    output logic        err_proto,
    output logic        err_ovf,
    output logic        err_timeout
);

    ex_state_e        state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc_q, pc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             inc_pend_q, inc_pend_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ret_upd;
    logic [31:0]      ret_pc;
    logic             ovf_evt;

    usr_rf_wb_buf u_wb_buf (
        .clk           (clk),
        .rstn          (rstn),
        .wb_we_i       (wb_we),
        .wb_wreg_i     (wb_wreg),
        .wb_wdata_i    (wb_wdata),
        .cpu_rf_we_i   (cpu_rf_we),
        .rf_ov_we_o    (rf_ov_we),
        .rf_ov_waddr_o (rf_ov_waddr),
        .rf_ov_wdata_o (rf_ov_wdata),
        .ovf_o         (ovf_evt)
    );

    // Execute FSM: next state, handshake outputs, retire/timeout PC request, sticky errors
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ret_upd   = 1'b0;
        ret_pc    = pc_q + PC_INC;
        inj_valid = 1'b0;
        ex_finish = 1'b0;
        if (ovf_evt) begin
            err_d[ERR_OVF] = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (ex_flag) begin
                    state_d = ST_ISSUE;
                    inst_d  = ex_inst;
                end
            end
            ST_ISSUE: begin
                inj_valid = 1'b1;
                if (ex_flag) begin
                    err_d[ERR_PROTO] = 1'b1;
                end
                if (inj_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (ex_flag) begin
                    err_d[ERR_PROTO] = 1'b1;
                end
                cnt_d = cnt_q + 8'd1;
                if (cpu_retire) begin
                    state_d = ST_DONE;
                    ret_upd = 1'b1;
                    if (cpu_npc_vld) begin
                        ret_pc = cpu_npc;
                    end
                end else if (cnt_d == TIMEOUT) begin
                    // Give up on the retire and step past the instruction
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_DONE;
                    ret_upd            = 1'b1;
                end
            end
            ST_DONE: begin
                ex_finish = 1'b1;
                if (ex_flag) begin
                    state_d = ST_ISSUE;
                    inst_d  = ex_inst;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arch PC: overwrite beats retire update beats increment; a losing increment stays pending
    always_comb begin
        pc_d       = pc_q;
        inc_pend_d = inc_pend_q;
        if (pc_we) begin
            pc_d       = pc;
            inc_pend_d = 1'b0;
        end else if (ret_upd) begin
            pc_d       = ret_pc;
            inc_pend_d = inc_pend_q | pc_inc;
        end else if (pc_inc || inc_pend_q) begin
            pc_d       = pc_q + PC_INC;
            inc_pend_d = pc_inc & inc_pend_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            inst_q     <= 32'd0;
            pc_q       <= RESET_PC;
            cnt_q      <= 8'd0;
            inc_pend_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            inc_pend_q <= inc_pend_d;
            err_q      <= err_d;
        end
    end

    assign inj_inst    = inst_q;
    assign inj_pc      = pc_q;
    assign arch_pc     = pc_q;
    assign err_proto   = err_q[ERR_PROTO];
    assign err_ovf     = err_q[ERR_OVF];
    assign err_timeout = err_q[ERR_TIMEOUT];

endmodule

// File: tb/tb_usr_ex_responder.sv
// Scoreboard bench for usr_ex_responder: directed scenarios then random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_usr_ex_responder;

    localparam logic [31:0] RPC = 32'h1C00_0000;
    localparam int          TO  = 255;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_flag, pc_inc, pc_we, wb_we, inj_ready, cpu_retire, cpu_npc_vld, cpu_rf_we;
    logic [31:0] ex_inst, pc, wb_wdata, cpu_npc;
    logic [4:0]  wb_wreg;
    logic        ex_finish, inj_valid, rf_ov_we, err_proto, err_ovf, err_timeout;
    logic [31:0] inj_inst, inj_pc, rf_ov_wdata, arch_pc;
    logic [4:0]  rf_ov_waddr;

    always #5 clk = ~clk;

    usr_ex_responder dut (
        .clk(clk), .rstn(rstn), .ex_flag(ex_flag), .ex_inst(ex_inst), .ex_finish(ex_finish),
        .pc_inc(pc_inc), .pc_we(pc_we), .pc(pc), .wb_we(wb_we), .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata), .inj_valid(inj_valid), .inj_inst(inj_inst), .inj_pc(inj_pc),
        .inj_ready(inj_ready), .cpu_retire(cpu_retire), .cpu_npc_vld(cpu_npc_vld),
        .cpu_npc(cpu_npc), .cpu_rf_we(cpu_rf_we), .rf_ov_we(rf_ov_we),
        .rf_ov_waddr(rf_ov_waddr), .rf_ov_wdata(rf_ov_wdata), .arch_pc(arch_pc),
        .err_proto(err_proto), .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    // per-cycle expectation: arch_pc, {timeout,ovf,proto}, inj_valid, ex_finish
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  err;
        logic        iv;
        logic        fin;
    } cyc_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    cyc_t  q_cyc[$];
    pair_t q_inj[$];
    pair_t q_wb[$];
    int    n_chk = 0;
    int    n_err = 0;

    // reference model state
    int          m_ph;
    logic [31:0] m_inst, m_pc;
    logic        m_owed;
    int          m_wait;
    logic [2:0]  m_err;
    pair_t       m_buf[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_inst = 32'd0; m_pc = RPC; m_owed = 1'b0; m_wait = 0; m_err = 3'b0;
        m_buf.delete();
    endtask

    task automatic idle_in();
        ex_flag = 0; pc_inc = 0; pc_we = 0; wb_we = 0; inj_ready = 0;
        cpu_retire = 0; cpu_npc_vld = 0; cpu_rf_we = 0;
    endtask

    // One clock cycle: record what the DUT must show this cycle, advance the model, step the clock.
    task automatic cyc();
        cyc_t        e;
        logic        ret, v;
        logic [31:0] rpc;
        pair_t       w;
        if (!rstn) begin
            model_reset();
            q_cyc.push_back({RPC, 3'b000, 1'b0, 1'b0});
        end else begin
            e.pc = m_pc; e.err = m_err; e.iv = (m_ph == P_ISSUE); e.fin = (m_ph == P_DONE);
            q_cyc.push_back(e);
            ret = 1'b0; rpc = m_pc + 32'd4;
            case (m_ph)
                P_IDLE: if (ex_flag) begin m_ph = P_ISSUE; m_inst = ex_inst; end
                P_ISSUE: begin
                    if (ex_flag) m_err[0] = 1'b1;
                    if (inj_ready) begin
                        q_inj.push_back({m_inst, m_pc});
                        m_ph = P_WAIT; m_wait = 0;
                    end
                end
                P_WAIT: begin
                    if (ex_flag) m_err[0] = 1'b1;
                    m_wait++;
                    if (cpu_retire) begin
                        ret = 1'b1; m_ph = P_DONE;
                        if (cpu_npc_vld) rpc = cpu_npc;
                    end else if (m_wait == TO) begin
                        ret = 1'b1; m_ph = P_DONE; m_err[2] = 1'b1;
                    end
                end
                default: begin
                    if (ex_flag) begin m_ph = P_ISSUE; m_inst = ex_inst; end
                    else m_ph = P_IDLE;
                end
            endcase
            // one owed increment is remembered when it loses to a retire
            if (pc_we) begin
                m_pc = pc; m_owed = 1'b0;
            end else if (ret) begin
                m_pc = rpc; if (pc_inc) m_owed = 1'b1;
            end else if (pc_inc || m_owed) begin
                m_pc = m_pc + 32'd4; m_owed = pc_inc && m_owed;
            end
            v = wb_we && (wb_wreg != 5'd0);
            w = {27'd0, wb_wreg, wb_wdata};
            if (!cpu_rf_we) begin
                if (m_buf.size() > 0) begin
                    q_wb.push_back(m_buf.pop_front());
                    if (v) m_buf.push_back(w);
                end else if (v) begin
                    q_wb.push_back(w);
                end
            end else if (v) begin
                if (m_buf.size() > 0) m_err[1] = 1'b1;
                else m_buf.push_back(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle sample compared against the scoreboard
    always @(negedge clk) begin
        cyc_t  e;
        pair_t p;
        if (q_cyc.size() > 0) begin
            e = q_cyc.pop_front();
            chk("cycle", {27'd0, arch_pc, err_timeout, err_ovf, err_proto, inj_valid, ex_finish},
                {27'd0, e});
            if (inj_valid && inj_ready) begin
                if (q_inj.size() == 0) chk("unexpected issue", {32'd0, inj_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin p = q_inj.pop_front(); chk("issue", {inj_inst, inj_pc}, p); end
            end
            if (rf_ov_we) begin
                if (q_wb.size() == 0) chk("unexpected rf write", {27'd0, rf_ov_waddr, rf_ov_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin p = q_wb.pop_front(); chk("rf write", {27'd0, rf_ov_waddr, rf_ov_wdata}, p); end
            end
        end
    end

    task automatic issue(input logic [31:0] inst);
        ex_flag = 1; ex_inst = inst; cyc(); idle_in();
        inj_ready = 1; cyc(); idle_in();
    endtask

    initial begin
        int          k;
        logic [31:0] pc0;
        rstn = 0; ex_inst = 0; pc = 0; wb_wreg = 0; wb_wdata = 0; cpu_npc = 0;
        idle_in(); model_reset();
        @(posedge clk); #1;
        cyc(); cyc();
        chk("reset arch_pc", arch_pc, RPC);
        chk("reset outputs", {ex_finish, inj_valid, rf_ov_we, err_proto, err_ovf, err_timeout}, 0);
        rstn = 1; cyc();

        // plain retire
        ex_flag = 1; ex_inst = 32'h02800C21; cyc(); idle_in();
        inj_ready = 1; #1;
        chk("first offer", {inj_valid, inj_inst, inj_pc}, {1'b1, 32'h02800C21, RPC});
        cyc(); idle_in();
        cyc(); cyc();
        cpu_retire = 1; cyc(); idle_in();
        chk("finish after retire", ex_finish, 1);
        chk("pc after retire", arch_pc, 32'h1C000004);
        cyc();

        // redirect, back-to-back issue from DONE
        issue(32'h11111111); cyc();
        cpu_retire = 1; cpu_npc_vld = 1; cpu_npc = 32'h1C000100; cyc(); idle_in();
        chk("redirect finish", ex_finish, 1);
        ex_flag = 1; ex_inst = 32'h22222222; cyc(); idle_in();
        chk("back-to-back offer", {inj_valid, inj_pc}, {1'b1, 32'h1C000100});
        inj_ready = 1; cyc(); idle_in();

        // pc_inc coincident with retire
        cpu_retire = 1; cpu_npc_vld = 1; cpu_npc = 32'h1C000010; pc_inc = 1; cyc(); idle_in();
        chk("retire beats inc", arch_pc, 32'h1C000010);
        cyc();
        chk("pending inc applied", arch_pc, 32'h1C000014);
        pc_we = 1; pc = 32'h1C000200; pc_inc = 1; cyc(); idle_in();
        chk("pc_we beats inc", arch_pc, 32'h1C000200);

        // writeback buffering and overflow
        wb_we = 1; wb_wreg = 5; wb_wdata = 32'hDEADBEEF; cpu_rf_we = 1; cyc(); idle_in();
        wb_we = 1; wb_wreg = 7; wb_wdata = 32'h12345678; cpu_rf_we = 1; cyc(); idle_in();
        #1;
        chk("buffered drain", {rf_ov_we, rf_ov_waddr, rf_ov_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
        cyc();
        chk("overflow flag", err_ovf, 1);
        wb_we = 1; wb_wreg = 0; wb_wdata = 32'hCAFEF00D; #1;
        chk("r0 discarded", rf_ov_we, 0);
        cyc(); idle_in();
        wb_we = 1; wb_wreg = 9; wb_wdata = 32'h0BADF00D; #1;
        chk("bypass write", {rf_ov_we, rf_ov_waddr, rf_ov_wdata}, {1'b1, 5'd9, 32'h0BADF00D});
        cyc(); idle_in();

        // wrap
        pc_we = 1; pc = 32'hFFFFFFFC; cyc(); idle_in();
        pc_inc = 1; cyc(); idle_in();
        chk("pc wrap", arch_pc, 32'h0);

        // timeout
        issue(32'h33333333);
        pc0 = arch_pc; k = 0;
        while (!ex_finish && k < 400) begin cyc(); k++; end
        chk("timeout latency", k, TO);
        chk("timeout pc", arch_pc, pc0 + 32'd4);
        chk("timeout flag", err_timeout, 1);
        cyc();

        // protocol error then reset mid-flight
        issue(32'h44444444);
        ex_flag = 1; ex_inst = 32'h55555555; cyc(); idle_in();
        chk("proto flag", err_proto, 1);
        chk("proto keeps waiting", {inj_valid, ex_finish}, 0);
        rstn = 0; cyc();
        chk("mid reset pc", arch_pc, RPC);
        chk("mid reset outputs", {ex_finish, inj_valid, err_proto, err_ovf, err_timeout}, 0);
        rstn = 1; cyc(); cyc();
        chk("no finish after reset", ex_finish, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ex_flag     = ($urandom_range(0, 7) == 0);
            ex_inst     = $urandom();
            inj_ready   = $urandom_range(0, 1);
            cpu_retire  = ($urandom_range(0, 3) == 0);
            cpu_npc_vld = $urandom_range(0, 1);
            cpu_npc     = $urandom() & 32'hFFFFFFFC;
            pc_inc      = ($urandom_range(0, 5) == 0);
            pc_we       = ($urandom_range(0, 15) == 0);
            pc          = $urandom() & 32'hFFFFFFFC;
            wb_we       = ($urandom_range(0, 2) == 0);
            wb_wreg     = 5'($urandom_range(0, 31));
            wb_wdata    = $urandom();
            cpu_rf_we   = $urandom_range(0, 1);
            cyc();
        end
        idle_in();
        for (int i = 0; i < 6; i++) cyc();
        @(negedge clk); #1;
        chk("issues all seen", q_inj.size(), 0);
        chk("rf writes all seen", q_wb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
